// File: rtl/stepper_move_seq_pkg.sv
// Shared types and constants for the stepper move sequencer.
package stepper_pkg;
  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 8;
  localparam int POS_W_DEF = 16;
endpackage

// File: rtl/stepper_move_seq_if.sv
// Move-command valid/ready channel into the sequencer.
interface stepper_move_seq_if #(
  parameter int CNT_W = stepper_pkg::CNT_W_DEF,
  parameter int DIV_W = stepper_pkg::DIV_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/stepper_move_seq_timer.sv
// step_timer: loadable down-counter that paces the gap between step pulses.
module step_timer #(
  parameter int DIV_W = 8
) (
  input  logic             drv_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic [DIV_W-1:0] value,
  output logic             expire
);
  // Expire on the last idle cycle so the next cycle is the step.
  assign expire = (value == DIV_W'(1));

  // Load wins over count; counting stops at zero.
  always_ff @(posedge drv_clk) begin
    if (reset)                           value <= '0;
    else if (load)                       value <= load_val;
    else if (en && value != '0)          value <= value - DIV_W'(1);
  end
endmodule

// File: rtl/stepper_move_seq.sv
// stepper_move_seq: paces forw/rev step pulses for a move command, tracks
// absolute position, supports abort. Optional soft position limits are
// enabled with the STEP_SOFT_LIMIT_EN macro (adds the limit_hit port).
module stepper_move_seq
  import stepper_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int POS_W   = POS_W_DEF,
  parameter int POS_MIN = -1000,
  parameter int POS_MAX = 1000
) (
  input  logic             drv_clk,
  input  logic             reset,
  stepper_move_seq_if.slave cmd,
  input  logic             abort,
  output logic             forw,
  output logic             rev,
  output logic             busy,
  output logic             move_done,
  output logic [CNT_W-1:0] steps_left,
  output logic [POS_W-1:0] position
`ifdef STEP_SOFT_LIMIT_EN
  ,
  output logic             limit_hit
`endif
);
`ifdef STEP_SOFT_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  localparam logic [POS_W-1:0] POS_MAX_C = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_MIN_C = POS_W'(POS_MIN);

  state_t           state_q, state_d;
  logic             dir_q;
  logic [DIV_W-1:0] period_q;
  logic [CNT_W-1:0] step_dec;
  logic             at_limit, step_ok, accept;
  logic             tmr_load, tmr_expire;
  logic [DIV_W-1:0] tmr_value;

  assign accept   = (state_q == IDLE) && cmd.cmd_valid;
  assign step_dec = steps_left - CNT_W'(1);
  // A step that would leave the soft window is swallowed.
  assign at_limit = LIM_EN && (state_q == STEP) &&
                    ((dir_q == DIR_FWD) ? (position == POS_MAX_C) : (position == POS_MIN_C));
  assign step_ok  = (state_q == STEP) && !at_limit;

  assign forw          = step_ok && (dir_q == DIR_FWD);
  assign rev           = step_ok && (dir_q == DIR_REV);
  assign busy          = (state_q == STEP) || (state_q == WAIT);
  assign move_done     = (state_q == DONE);
  assign cmd.cmd_ready = (state_q == IDLE);

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .drv_clk  (drv_clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (state_q == WAIT),
    .load_val (period_q),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  // State register.
  always_ff @(posedge drv_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and timer reload.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: if (cmd.cmd_valid) state_d = (cmd.cmd_steps == '0) ? DONE : STEP;
      STEP: begin
        if (at_limit || step_dec == '0 || abort) state_d = DONE;
        else if (period_q == '0)                 state_d = STEP;
        else begin
          state_d  = WAIT;
          tmr_load = 1'b1;
        end
      end
      WAIT: begin
        if (abort)           state_d = DONE;
        else if (tmr_expire) state_d = STEP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, step count and position tracking.
  always_ff @(posedge drv_clk) begin
    if (reset) begin
      dir_q      <= DIR_FWD;
      period_q   <= '0;
      steps_left <= '0;
      position   <= '0;
    end else begin
      if (accept) begin
        dir_q    <= cmd.cmd_dir;
        period_q <= cmd.cmd_period;
        if (cmd.cmd_steps != '0) steps_left <= cmd.cmd_steps;
      end
      if (step_ok) begin
        steps_left <= step_dec;
        position   <= (dir_q == DIR_REV) ? position - POS_W'(1) : position + POS_W'(1);
      end
    end
  end

`ifdef STEP_SOFT_LIMIT_EN
  // Sticky limit flag, cleared by the next accepted command.
  always_ff @(posedge drv_clk) begin
    if (reset || accept) limit_hit <= 1'b0;
    else if (at_limit)   limit_hit <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_stepper_move_seq.sv
// Directed bench for stepper_move_seq; the soft-limit scenario replaces the
// default scenarios when STEP_SOFT_LIMIT_EN is defined.
module tb_stepper_move_seq;
`ifdef STEP_SOFT_LIMIT_EN
  localparam int TB_POS_MAX = 2;
`else
  localparam int TB_POS_MAX = 1000;
`endif

  logic        drv_clk = 1'b0;
  logic        reset;
  logic        abort;
  logic        forw, rev, busy, move_done;
  logic [7:0]  steps_left;
  logic [15:0] position;
`ifdef STEP_SOFT_LIMIT_EN
  logic        limit_hit;
`endif
  int errors = 0;
  int checks = 0;

  stepper_move_seq_if #(.CNT_W(8), .DIV_W(8)) cmd ();

  stepper_move_seq #(
    .CNT_W(8), .DIV_W(8), .POS_W(16), .POS_MIN(-1000), .POS_MAX(TB_POS_MAX)
  ) dut (
    .drv_clk    (drv_clk),
    .reset      (reset),
    .cmd        (cmd),
    .abort      (abort),
    .forw       (forw),
    .rev        (rev),
    .busy       (busy),
    .move_done  (move_done),
    .steps_left (steps_left),
    .position   (position)
`ifdef STEP_SOFT_LIMIT_EN
    ,
    .limit_hit  (limit_hit)
`endif
  );

  always #5 drv_clk = ~drv_clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge drv_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic dir, input logic [7:0] n, input logic [7:0] p);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_dir    = dir;
    cmd.cmd_steps  = n;
    cmd.cmd_period = p;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_forw"},  32'(forw), 0);
    chk({tag, "_rev"},   32'(rev), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(move_done), 0);
    chk({tag, "_ready"}, 32'(cmd.cmd_ready), 1);
    chk({tag, "_pos"},   32'(position), 0);
    chk({tag, "_left"},  32'(steps_left), 0);
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0;
    cmd.cmd_valid = 1'b0; cmd.cmd_dir = 1'b0; cmd.cmd_steps = '0; cmd.cmd_period = '0;
    tick(); tick();
    chk_reset("rst");
`ifdef STEP_SOFT_LIMIT_EN
    chk("rst_limit", 32'(limit_hit), 0);
`endif
    reset = 1'b0;
    tick();

`ifdef STEP_SOFT_LIMIT_EN
    // Forward 5 with POS_MAX=2: two pulses, third step swallowed.
    send(1'b0, 8'd5, 8'd0); tick(); cmd.cmd_valid = 1'b0;
    chk("lim_s1", 32'(forw), 1);
    tick(); chk("lim_s2", 32'(forw), 1);
    tick(); chk("lim_s3_forw", 32'(forw), 0); chk("lim_s3_pos", 32'(position), 2);
    tick(); chk("lim_done", 32'(move_done), 1); chk("lim_hit", 32'(limit_hit), 1);
    chk("lim_left", 32'(steps_left), 3); chk("lim_pos", 32'(position), 2);
    tick(); chk("lim_sticky", 32'(limit_hit), 1); chk("lim_ready", 32'(cmd.cmd_ready), 1);
`else
    // Forward N=3, P=0: back-to-back pulses, done at k+4.
    send(1'b0, 8'd3, 8'd0); tick(); cmd.cmd_valid = 1'b0;
    chk("t1_s1", 32'(forw), 1); chk("t1_busy", 32'(busy), 1); chk("t1_ready", 32'(cmd.cmd_ready), 0);
    tick(); chk("t1_s2", 32'(forw), 1);
    tick(); chk("t1_s3", 32'(forw), 1); chk("t1_pos_mid", 32'(position), 2);
    tick(); chk("t1_done", 32'(move_done), 1); chk("t1_forw_off", 32'(forw), 0);
    chk("t1_pos", 32'(position), 3); chk("t1_left", 32'(steps_left), 0);
    tick(); chk("t1_idle", 32'(cmd.cmd_ready), 1);

    // Reverse N=2, P=2: pulses at k+1, k+4; done at k+5.
    send(1'b1, 8'd2, 8'd2); tick(); cmd.cmd_valid = 1'b0;
    chk("t2_s1", 32'(rev), 1); chk("t2_s1_forw", 32'(forw), 0);
    tick(); chk("t2_gap", 32'(rev), 0); chk("t2_gap_busy", 32'(busy), 1);
    tick(); chk("t2_gap2", 32'(rev), 0);
    tick(); chk("t2_s2", 32'(rev), 1);
    tick(); chk("t2_done", 32'(move_done), 1); chk("t2_pos", 32'(position), 1);
    tick();

    // Zero steps: done at k+1, no pulse.
    send(1'b0, 8'd0, 8'd0); tick(); cmd.cmd_valid = 1'b0;
    chk("t3_done", 32'(move_done), 1); chk("t3_forw", 32'(forw), 0);
    chk("t3_busy", 32'(busy), 0); chk("t3_pos", 32'(position), 1);
    tick();

    // Forward N=10, P=3, abort in the WAIT after step 2.
    send(1'b0, 8'd10, 8'd3); tick(); cmd.cmd_valid = 1'b0;
    chk("t4_s1", 32'(forw), 1);
    tick(); tick(); tick();
    tick(); chk("t4_s2", 32'(forw), 1);
    tick(); abort = 1'b1; chk("t4_wait", 32'(forw), 0);
    tick(); abort = 1'b0;
    chk("t4_done", 32'(move_done), 1); chk("t4_left", 32'(steps_left), 8);
    chk("t4_pos", 32'(position), 3); chk("t4_forw", 32'(forw), 0);
    tick();

    // cmd_valid held with changed fields mid-move is ignored; then reset mid-move.
    send(1'b1, 8'd3, 8'd1); tick();
    cmd.cmd_dir = 1'b0; cmd.cmd_steps = 8'd7;
    chk("t5_s1", 32'(rev), 1);
    tick(); chk("t5_ready", 32'(cmd.cmd_ready), 0); chk("t5_left", 32'(steps_left), 2);
    chk("t5_pos", 32'(position), 2);
    tick(); chk("t5_s2", 32'(rev), 1); chk("t5_s2_forw", 32'(forw), 0);
    reset = 1'b1; cmd.cmd_valid = 1'b0;
    tick(); chk_reset("t5_rst");
    reset = 1'b0;
    tick();

    // Reverse one step from 0 wraps to all ones.
    send(1'b1, 8'd1, 8'd0); tick(); cmd.cmd_valid = 1'b0;
    chk("t6_s1", 32'(rev), 1);
    tick(); chk("t6_done", 32'(move_done), 1); chk("t6_pos", 32'(position), 32'h0000_FFFF);
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
